seg_scan_ctrl: RTL

SEG_SCAN_CTRL -- requirements
Module: seg_scan_ctrl

---
 rtl/seg_scan_ctrl.sv | 121 ++++++++++++
 1 files changed

// File: rtl/seg_scan_ctrl.sv
// Eight-digit multiplexed 7-segment scan controller: time-shares one decoder across
// eight digits with a blanking guard before each digit and a frame-synchronous load handshake.
module seg_scan_ctrl #(
    parameter int ACT_CYC = 100_000,
    parameter int BLK_CYC = 1_000
) (
    input  logic        clk100M,
    input  logic        sys_rst_n,
    input  logic [31:0] digits,
    input  logic [7:0]  dp_mask,
    input  logic [7:0]  en_mask,
    input  logic        load,
    output logic        ready,
    input  logic        blank_all,
    output logic [3:0]  dig_val,
    output logic        dp_en,
    output logic [7:0]  AN,
    output logic        frame_done
);

    localparam int MAX_CYC = (ACT_CYC > BLK_CYC) ? ACT_CYC : BLK_CYC;
    localparam int CNT_W   = $clog2(MAX_CYC);
    localparam logic [CNT_W-1:0] ACT_LAST = CNT_W'(ACT_CYC - 1);
    localparam logic [CNT_W-1:0] BLK_LAST = CNT_W'((BLK_CYC == 0) ? 0 : BLK_CYC - 1);

    typedef enum logic {BLANK, ACTIVE} state_t;
    localparam state_t START_ST = (BLK_CYC == 0) ? ACTIVE : BLANK;

    state_t           state, state_nxt;
    logic [2:0]       idx, idx_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;

    logic [31:0] sh_dig, pd_dig, sh_dig_nxt;
    logic [7:0]  sh_dp, sh_en, pd_dp, pd_en, sh_dp_nxt, sh_en_nxt;

    logic        capture, commit;
    logic [7:0]  an_nxt;
    logic [3:0]  dig_nxt;
    logic        dp_nxt, fd_nxt;

    // Pending data exists exactly while ready is low, so a frame_done seen with
    // ready low always belongs to a capture made in an earlier cycle.
    assign capture = load & ready;
    assign commit  = frame_done & ~ready;

    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        cnt_nxt   = cnt + CNT_W'(1);
        case (state)
            BLANK: begin
                if (cnt == BLK_LAST) begin
                    state_nxt = ACTIVE;
                    cnt_nxt   = '0;
                end
            end
            ACTIVE: begin
                if (cnt == ACT_LAST) begin
                    state_nxt = (BLK_CYC == 0) ? ACTIVE : BLANK;
                    idx_nxt   = idx + 3'd1;
                    cnt_nxt   = '0;
                end
            end
            default: begin
                state_nxt = START_ST;
                cnt_nxt   = '0;
            end
        endcase

        sh_dig_nxt = commit ? pd_dig : sh_dig;
        sh_dp_nxt  = commit ? pd_dp  : sh_dp;
        sh_en_nxt  = commit ? pd_en  : sh_en;

        // Outputs are derived from the next state so they register in step with it.
        an_nxt = 8'hFF;
        if (state_nxt == ACTIVE && sh_en_nxt[idx_nxt] && !blank_all)
            an_nxt[idx_nxt] = 1'b0;
        dig_nxt = sh_dig_nxt[{idx_nxt, 2'b00} +: 4];
        dp_nxt  = sh_dp_nxt[idx_nxt];
        fd_nxt  = (state_nxt == ACTIVE) && (idx_nxt == 3'd7) && (cnt_nxt == ACT_LAST);
    end

    always_ff @(posedge clk100M or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state      <= START_ST;
            idx        <= '0;
            cnt        <= '0;
            AN         <= 8'hFF;
            dig_val    <= '0;
            dp_en      <= 1'b0;
            frame_done <= 1'b0;
            ready      <= 1'b1;
            sh_dig     <= '0;
            sh_dp      <= '0;
            sh_en      <= 8'hFF;
            pd_dig     <= '0;
            pd_dp      <= '0;
            pd_en      <= 8'hFF;
        end else begin
            state      <= state_nxt;
            idx        <= idx_nxt;
            cnt        <= cnt_nxt;
            AN         <= an_nxt;
            dig_val    <= dig_nxt;
            dp_en      <= dp_nxt;
            frame_done <= fd_nxt;
            sh_dig     <= sh_dig_nxt;
            sh_dp      <= sh_dp_nxt;
            sh_en      <= sh_en_nxt;
            if (capture) begin
                pd_dig <= digits;
                pd_dp  <= dp_mask;
                pd_en  <= en_mask;
                ready  <= 1'b0;
            end else if (commit) begin
                ready  <= 1'b1;
            end
        end
    end

endmodule
